// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake. Logic and add/sub ops complete one cycle after
// capture; shifts iterate one bit per cycle with busy held high until the final step.
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic [3:0]       ctrl,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic             err,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;
    localparam logic [3:0] OpAnd = 4'd2;
    localparam logic [3:0] OpOr  = 4'd3;
    localparam logic [3:0] OpXor = 4'd4;
    localparam logic [3:0] OpNot = 4'd5;
    localparam logic [3:0] OpSla = 4'd6;
    localparam logic [3:0] OpSra = 4'd7;
    localparam logic [3:0] OpSrl = 4'd8;

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic             cin_q, cin_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             sla_ovf_q, sla_ovf_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   add_sum, sub_sum;
    logic [WIDTH-1:0] op_res;
    logic             op_cout, op_ovf, op_err;
    logic [WIDTH-1:0] step_acc;
    logic             step_out, step_chg;
    logic [SHW-1:0]   shamt_in;
    logic             is_shift_in;

    assign shamt_in    = B[SHW-1:0];
    assign is_shift_in = (ctrl == OpSla) || (ctrl == OpSra) || (ctrl == OpSrl);

    assign add_sum = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    assign sub_sum = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};

    // Single-cycle result for the operation captured on the previous edge.
    always_comb begin
        op_res  = '0;
        op_cout = 1'b0;
        op_ovf  = 1'b0;
        op_err  = 1'b0;
        case (ctrl_q)
            OpAdd: begin
                op_res  = add_sum[WIDTH-1:0];
                op_cout = add_sum[WIDTH];
                op_ovf  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OpSub: begin
                op_res  = sub_sum[WIDTH-1:0];
                op_cout = sub_sum[WIDTH];
                op_ovf  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OpAnd: op_res = a_q & b_q;
            OpOr:  op_res = a_q | b_q;
            OpXor: op_res = a_q ^ b_q;
            OpNot: op_res = ~a_q;
            OpSla, OpSra, OpSrl: op_res = a_q;  // only reached with shamt = 0
            default: op_err = 1'b1;
        endcase
    end

    // One-bit shift step on the accumulator.
    always_comb begin
        step_acc = acc_q;
        step_out = 1'b0;
        step_chg = 1'b0;
        case (ctrl_q)
            OpSla: begin
                step_acc = {acc_q[WIDTH-2:0], 1'b0};
                step_out = acc_q[WIDTH-1];
                step_chg = acc_q[WIDTH-1] ^ acc_q[WIDTH-2];
            end
            OpSra: begin
                step_acc = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                step_out = acc_q[0];
            end
            OpSrl: begin
                step_acc = {1'b0, acc_q[WIDTH-1:1]};
                step_out = acc_q[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        ctrl_d    = ctrl_q;
        cin_d     = cin_q;
        pend_d    = 1'b0;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sla_ovf_d = sla_ovf_q;
        res_d     = res_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        err_d     = err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        // A pending single-cycle op retires while a new start may be captured on the same edge.
        if (pend_q) begin
            res_d  = op_res;
            cout_d = op_cout;
            ovf_d  = op_ovf;
            err_d  = op_err;
            done_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d    = A;
                    b_d    = B;
                    ctrl_d = ctrl;
                    cin_d  = cin;
                    if (is_shift_in && (shamt_in != '0)) begin
                        state_d   = StShift;
                        acc_d     = A;
                        cnt_d     = shamt_in;
                        sla_ovf_d = 1'b0;
                        busy_d    = 1'b1;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            StShift: begin
                acc_d     = step_acc;
                cnt_d     = cnt_q - SHW'(1);
                sla_ovf_d = sla_ovf_q | step_chg;
                if (cnt_q == SHW'(1)) begin
                    res_d   = step_acc;
                    cout_d  = step_out;
                    ovf_d   = (ctrl_q == OpSla) && (sla_ovf_q || step_chg);
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (done_d) begin
            zero_d = (res_d == '0);
            neg_d  = res_d[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= '0;
            cin_q     <= 1'b0;
            pend_q    <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sla_ovf_q <= 1'b0;
            res_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ctrl_q    <= ctrl_d;
            cin_q     <= cin_d;
            pend_q    <= pend_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sla_ovf_q <= sla_ovf_d;
            res_q     <= res_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
            neg_q     <= neg_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign res  = res_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;
    assign neg  = neg_q;
    assign err  = err_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a whole-operation reference model checked every cycle, plus directed
// vectors with hand-computed literal expectations.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        cin = 1'b0;
    logic [3:0]  ctrl = '0;
    logic [31:0] res;
    logic        cout, ovf, zero, neg, err, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq #(.WIDTH(32), .SHW(5)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .A    (A),
        .B    (B),
        .cin  (cin),
        .ctrl (ctrl),
        .res  (res),
        .cout (cout),
        .ovf  (ovf),
        .zero (zero),
        .neg  (neg),
        .err  (err),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    // Whole-operation model: result of an op computed directly from its operands.
    function automatic void model_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                     input logic ci, output logic [31:0] r, output logic co,
                                     output logic ov, output logic er, output int lat,
                                     output logic sh);
        int          k;
        longint      sd;
        logic [32:0] top, mask;
        k = int'(b[4:0]);
        r = '0; co = 1'b0; ov = 1'b0; er = 1'b0; lat = 1; sh = 1'b0;
        case (c)
            4'd0: begin
                sd = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
                r  = a + b + 32'(ci);
                co = ({32'd0, a} + {32'd0, b} + 64'(ci)) > 64'hFFFF_FFFF;
                ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
            end
            4'd1: begin
                sd = longint'($signed(a)) - longint'($signed(b));
                r  = a - b;
                co = (a >= b);
                ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6, 4'd7, 4'd8: begin
                if (k == 0) begin
                    r = a;
                end else begin
                    lat = k;
                    sh  = 1'b1;
                    if (c == 4'd6) begin
                        r    = a << k;
                        co   = a[32-k];
                        top  = 33'(a >> (31 - k));
                        mask = (33'd1 << (k + 1)) - 33'd1;
                        ov   = (top != 33'd0) && (top != mask);
                    end else if (c == 4'd7) begin
                        r  = $unsigned($signed(a) >>> k);
                        co = a[k-1];
                    end else begin
                        r  = a >> k;
                        co = a[k-1];
                    end
                end
            end
            default: er = 1'b1;
        endcase
    endfunction

    typedef struct {
        logic [31:0] r;
        logic        co, ov, er, sh;
        int          cnt;
    } pend_t;

    pend_t       pq[$];
    pend_t       mp;
    logic [31:0] e_res = '0;
    logic        e_cout = 1'b0, e_ovf = 1'b0, e_zero = 1'b0, e_neg = 1'b0;
    logic        e_err = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    logic        was_busy;
    int          m_lat;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pq.delete();
            e_res = '0; e_cout = 1'b0; e_ovf = 1'b0; e_zero = 1'b0; e_neg = 1'b0;
            e_err = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        end else begin
            was_busy = e_busy;
            e_done   = 1'b0;
            for (int i = 0; i < pq.size(); i++) pq[i].cnt = pq[i].cnt - 1;
            if (pq.size() > 0 && pq[0].cnt == 0) begin
                e_res  = pq[0].r;
                e_cout = pq[0].co;
                e_ovf  = pq[0].ov;
                e_err  = pq[0].er;
                e_zero = (pq[0].r == 32'd0);
                e_neg  = pq[0].r[31];
                e_done = 1'b1;
                if (pq[0].sh) e_busy = 1'b0;
                void'(pq.pop_front());
            end
            if (start && !was_busy) begin
                model_op(ctrl, A, B, cin, mp.r, mp.co, mp.ov, mp.er, m_lat, mp.sh);
                mp.cnt = m_lat;
                pq.push_back(mp);
                if (mp.sh) e_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        n_cmp++;
        if ({res, cout, ovf, zero, neg, err, busy, done} !==
            {e_res, e_cout, e_ovf, e_zero, e_neg, e_err, e_busy, e_done}) begin
            n_bad++;
            $display("FAIL cycle t=%0t got res=%h c=%b v=%b z=%b n=%b e=%b busy=%b done=%b expected res=%h c=%b v=%b z=%b n=%b e=%b busy=%b done=%b",
                     $time, res, cout, ovf, zero, neg, err, busy, done,
                     e_res, e_cout, e_ovf, e_zero, e_neg, e_err, e_busy, e_done);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic ci);
        @(posedge clk);
        #1;
        ctrl = c; A = a; B = b; cin = ci; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns the number of cycles after the sampling edge until done, and busy cycles seen.
    task automatic wait_done(input string name, input int maxc, output int lat, output int nbusy);
        bit got;
        got = 1'b0; lat = 0; nbusy = 0;
        for (int i = 0; i < maxc && !got; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                got = 1'b1;
                lat = i;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no done within %0d cycles expected done", name, maxc);
        end
    endtask

    int lat, nb;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        check("reset_res", res, 32'd0);
        check("reset_flags", 32'({cout, ovf, zero, neg, err, busy, done}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Reset in the middle of a shift aborts it without a done.
        issue(4'd8, 32'hFFFF_FFFF, 32'd8, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_res", res, 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);

        issue(4'd0, 32'h7FFF_FFFF, 32'd1, 1'b0);
        wait_done("add_ovf", 10, lat, nb);
        check("add_ovf_res", res, 32'h8000_0000);
        check("add_ovf_flags", 32'({cout, ovf, zero, neg}), 32'b0101);
        check("add_lat", 32'(lat), 32'd1);

        issue(4'd0, 32'hFFFF_FFFF, 32'd0, 1'b1);
        wait_done("add_carry", 10, lat, nb);
        check("add_carry_res", res, 32'd0);
        check("add_carry_flags", 32'({cout, ovf, zero, neg}), 32'b1010);

        issue(4'd1, 32'd3, 32'd5, 1'b1);
        wait_done("sub_borrow", 10, lat, nb);
        check("sub_borrow_res", res, 32'hFFFF_FFFE);
        check("sub_borrow_flags", 32'({cout, ovf, zero, neg}), 32'b0001);

        issue(4'd1, 32'd5, 32'd3, 1'b0);
        wait_done("sub_ok", 10, lat, nb);
        check("sub_ok_res", res, 32'd2);
        check("sub_ok_cout", 32'(cout), 32'd1);

        issue(4'd7, 32'h8000_0001, 32'd4, 1'b0);
        wait_done("sra", 10, lat, nb);
        check("sra_res", res, 32'hF800_0000);
        check("sra_cout", 32'(cout), 32'd0);
        check("sra_lat", 32'(lat), 32'd4);
        check("sra_busy_cycles", 32'(nb), 32'd4);

        // Start and operand changes while busy must be ignored.
        @(posedge clk);
        #1;
        ctrl = 4'd7; A = 32'h8000_0001; B = 32'd4; start = 1'b1;
        @(posedge clk);
        #1;
        ctrl = 4'd0; A = 32'd0; B = 32'd0;
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("sra_busy_start", 10, lat, nb);
        check("sra_busy_start_res", res, 32'hF800_0000);

        issue(4'd6, 32'h4000_0000, 32'd1, 1'b0);
        wait_done("sla_ovf", 10, lat, nb);
        check("sla_ovf_res", res, 32'h8000_0000);
        check("sla_ovf_flags", 32'({cout, ovf}), 32'b01);
        check("sla_ovf_lat", 32'(lat), 32'd1);

        issue(4'd6, 32'h4000_0000, 32'h20, 1'b0);
        wait_done("sla_zero_shamt", 10, lat, nb);
        check("sla_zero_shamt_res", res, 32'h4000_0000);
        check("sla_zero_shamt_cout", 32'(cout), 32'd0);
        check("sla_zero_shamt_busy", 32'(nb), 32'd0);

        issue(4'd6, 32'hC000_0003, 32'd2, 1'b0);
        wait_done("sla2", 10, lat, nb);
        check("sla2_res", res, 32'h0000_000C);
        check("sla2_flags", 32'({cout, ovf}), 32'b11);

        issue(4'd8, 32'hFFFF_FFFF, 32'd31, 1'b0);
        wait_done("srl31", 40, lat, nb);
        check("srl31_res", res, 32'd1);
        check("srl31_lat", 32'(lat), 32'd31);

        issue(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        wait_done("illegal", 10, lat, nb);
        check("illegal_res", res, 32'd0);
        check("illegal_flags", 32'({err, zero, cout, ovf, neg}), 32'b11000);

        // Back-to-back single-cycle ops.
        @(posedge clk);
        #1;
        A = 32'hF0F0_F0F0; B = 32'hFF00_FF00; ctrl = 4'd2; start = 1'b1;
        @(posedge clk);
        #1 ctrl = 4'd4;
        @(posedge clk);
        #1 ctrl = 4'd5;
        @(negedge clk);
        check("b2b_and", res, 32'hF000_F000);
        check("b2b_and_done_err", 32'({done, err}), 32'b10);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("b2b_xor", res, 32'h0FF0_0FF0);
        check("b2b_xor_done", 32'(done), 32'd1);
        @(negedge clk);
        check("b2b_not", res, 32'h0F0F_0F0F);
        check("b2b_not_done", 32'(done), 32'd1);
        @(negedge clk);
        check("b2b_idle_done", 32'(done), 32'd0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
